// File: rtl/hazard_fwd_pkg.sv
// Shared definitions for the hazard / forwarding unit.
//   - fwd_sel encodings driven per source operand
//   - FSM state encoding for the load-latency stall controller
package hazard_fwd_pkg;

  // Operand source selects for the EX-stage operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM = 2'b01;  // result sitting in MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // result sitting in WB

  // Load-latency stall controller states.
  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_MEM_WAIT    = 2'd1,
    ST_MEM_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/fwd_sel_cmp.sv
// Forward-select comparator for one EX source operand.
// Ports:
//   src_addr_i      EX source register address of this operand
//   mem_reg_rd_i    MEM destination register
//   mem_reg_write_i MEM writes the register file
//   wb_reg_rd_i     WB destination register
//   wb_reg_write_i  WB writes the register file
//   fwd_sel_o       FWD_MEM / FWD_WB / FWD_RF; MEM wins over WB (newer value)
module fwd_sel_cmp
  import hazard_fwd_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_addr_i,
  input  logic [AW-1:0] mem_reg_rd_i,
  input  logic          mem_reg_write_i,
  input  logic [AW-1:0] wb_reg_rd_i,
  input  logic          wb_reg_write_i,
  output logic [1:0]    fwd_sel_o
);

  // Register 0 is hard-wired to zero, so a write to it never forwards.
  always_comb begin
    // NOTE: assign a default first so every path drives the output; a
    // missing branch would otherwise infer a latch.
    fwd_sel_o = FWD_RF;
    if (mem_reg_write_i && (mem_reg_rd_i != '0) && (mem_reg_rd_i == src_addr_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (wb_reg_write_i && (wb_reg_rd_i != '0) && (wb_reg_rd_i == src_addr_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detection and forwarding control.
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset
//   id_valid, id_src_addr  ID-stage instruction and its packed source addresses
//   exe_src_addr           EX-stage packed source addresses (forwarding compare)
//   exe_mem_read/reg_rd    EX load flag and destination (load-use detection)
//   mem_mem_read           MEM holds a load (multi-cycle latency stall)
//   mem_reg_rd/reg_write   MEM destination / write enable (forwarding)
//   wb_reg_rd/reg_write    WB destination / write enable (forwarding)
//   cnt_clr                synchronous clear of both performance counters
//   fwd_sel                per-operand forward select, 2 bits per operand
//   stall_id, bubble_ex    load-use stall of PC/IF/ID plus EX bubble
//   stall_all              whole-pipeline freeze while a slow load completes
//   lu_stall_cnt           saturating count of load-use stall cycles
//   mem_stall_cnt          saturating count of load-latency stall cycles
module hazard_fwd_unit
  import hazard_fwd_pkg::*;
#(
  parameter int AW       = 5,
  parameter int N_OPS    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [N_OPS*AW-1:0]   id_src_addr,
  input  logic [N_OPS*AW-1:0]   exe_src_addr,
  input  logic                  exe_mem_read,
  input  logic [AW-1:0]         exe_reg_rd,
  input  logic                  mem_mem_read,
  input  logic [AW-1:0]         mem_reg_rd,
  input  logic                  mem_reg_write,
  input  logic [AW-1:0]         wb_reg_rd,
  input  logic                  wb_reg_write,
  input  logic                  cnt_clr,
  output logic [N_OPS*2-1:0]    fwd_sel,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  stall_all,
  output logic [CNT_W-1:0]      lu_stall_cnt,
  output logic [CNT_W-1:0]      mem_stall_cnt
);

  // A load with latency L needs L-1 freeze cycles; the first is spent in
  // ST_RUN, the remaining L-2 are counted down in wcnt.
  localparam bit         HAS_LAT     = (LOAD_LAT > 1);
  localparam int         WCNT_INIT_I = HAS_LAT ? (LOAD_LAT - 2) : 0;
  localparam logic [2:0] WCNT_INIT   = WCNT_INIT_I[2:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [2:0]       wcnt_q;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             lu_hit;

  // Forwarding: one independent comparator per EX source operand.
  for (genvar g = 0; g < N_OPS; g++) begin : g_op
    fwd_sel_cmp #(.AW(AW)) u_cmp (
      .src_addr_i      (exe_src_addr[g*AW +: AW]),
      .mem_reg_rd_i    (mem_reg_rd),
      .mem_reg_write_i (mem_reg_write),
      .wb_reg_rd_i     (wb_reg_rd),
      .wb_reg_write_i  (wb_reg_write),
      .fwd_sel_o       (fwd_sel[g*2 +: 2])
    );
  end

  // Load-use: the ID instruction reads the register an EX load is producing.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < N_OPS; i++) begin
      if (id_src_addr[i*AW +: AW] == exe_reg_rd) lu_hit = 1'b1;
    end
    lu_hit = lu_hit && exe_mem_read && (exe_reg_rd != '0) && id_valid;
  end

  // The freeze starts in the same cycle the load is first seen in MEM, so
  // stall_all is decoded from the state plus the live mem_mem_read.
  always_comb begin
    stall_all = 1'b0;
    case (state_q)
      ST_RUN:      stall_all = mem_mem_read && HAS_LAT;
      ST_MEM_WAIT: stall_all = 1'b1;
      default:     stall_all = 1'b0;
    endcase
  end

  // A full freeze already holds ID, so the load-use stall is suppressed and
  // simply re-evaluated once the freeze releases.
  assign stall_id  = lu_hit && !stall_all;
  assign bubble_ex = stall_id;

  // ST_MEM_RELEASE is one cycle where mem_mem_read is ignored: the finishing
  // load still sits in MEM and must not re-trigger the freeze.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: only control state is reset here; the reset is asynchronous so a
    // pending wait aborts immediately without needing a clock edge.
    if (!arst_n) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      case (state_q)
        ST_RUN: begin
          if (mem_mem_read && HAS_LAT) begin
            wcnt_q  <= WCNT_INIT;
            state_q <= (LOAD_LAT == 2) ? ST_MEM_RELEASE : ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          wcnt_q <= wcnt_q - 3'd1;
          if (wcnt_q == 3'd1) state_q <= ST_MEM_RELEASE;
        end
        ST_MEM_RELEASE: state_q <= ST_RUN;
        default:        state_q <= ST_RUN;
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (cnt_clr) begin
      lu_cnt_d  = '0;
      mem_cnt_d = '0;
    end else begin
      if (stall_id && (lu_cnt_q != CNT_MAX))   lu_cnt_d  = lu_cnt_q + CNT_ONE;
      if (stall_all && (mem_cnt_q != CNT_MAX)) mem_cnt_d = mem_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit. Three instances share all inputs
// and differ in LOAD_LAT / CNT_W (3/4, 4/16, 1/8), each tracked by its own
// behavioural model entry.
module tb_hazard_fwd_unit;

  localparam int AW    = 5;
  localparam int N_OPS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                arst_n;
  logic                id_valid;
  logic [N_OPS*AW-1:0] id_src_addr;
  logic [N_OPS*AW-1:0] exe_src_addr;
  logic                exe_mem_read;
  logic [AW-1:0]       exe_reg_rd;
  logic                mem_mem_read;
  logic [AW-1:0]       mem_reg_rd;
  logic                mem_reg_write;
  logic [AW-1:0]       wb_reg_rd;
  logic                wb_reg_write;
  logic                cnt_clr;

  logic [3:0]  fwd_a, fwd_b, fwd_c;
  logic        sid_a, sid_b, sid_c;
  logic        bex_a, bex_b, bex_c;
  logic        sall_a, sall_b, sall_c;
  logic [3:0]  lu_a,  mem_a;
  logic [15:0] lu_b,  mem_b;
  logic [7:0]  lu_c,  mem_c;

  hazard_fwd_unit #(.AW(AW), .N_OPS(N_OPS), .LOAD_LAT(3), .CNT_W(4)) u_a (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .exe_src_addr(exe_src_addr), .exe_mem_read(exe_mem_read), .exe_reg_rd(exe_reg_rd),
    .mem_mem_read(mem_mem_read), .mem_reg_rd(mem_reg_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_rd(wb_reg_rd), .wb_reg_write(wb_reg_write), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_a), .stall_id(sid_a), .bubble_ex(bex_a), .stall_all(sall_a),
    .lu_stall_cnt(lu_a), .mem_stall_cnt(mem_a));

  hazard_fwd_unit #(.AW(AW), .N_OPS(N_OPS), .LOAD_LAT(4), .CNT_W(16)) u_b (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .exe_src_addr(exe_src_addr), .exe_mem_read(exe_mem_read), .exe_reg_rd(exe_reg_rd),
    .mem_mem_read(mem_mem_read), .mem_reg_rd(mem_reg_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_rd(wb_reg_rd), .wb_reg_write(wb_reg_write), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_b), .stall_id(sid_b), .bubble_ex(bex_b), .stall_all(sall_b),
    .lu_stall_cnt(lu_b), .mem_stall_cnt(mem_b));

  hazard_fwd_unit #(.AW(AW), .N_OPS(N_OPS), .LOAD_LAT(1), .CNT_W(8)) u_c (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .exe_src_addr(exe_src_addr), .exe_mem_read(exe_mem_read), .exe_reg_rd(exe_reg_rd),
    .mem_mem_read(mem_mem_read), .mem_reg_rd(mem_reg_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_rd(wb_reg_rd), .wb_reg_write(wb_reg_write), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_c), .stall_id(sid_c), .bubble_ex(bex_c), .stall_all(sall_c),
    .lu_stall_cnt(lu_c), .mem_stall_cnt(mem_c));

  // Observed outputs gathered per instance.
  logic [3:0]  obs_fwd  [3];
  logic        obs_sid  [3];
  logic        obs_bex  [3];
  logic        obs_sall [3];
  logic [15:0] obs_lu   [3];
  logic [15:0] obs_mem  [3];

  assign obs_fwd[0]  = fwd_a;  assign obs_fwd[1]  = fwd_b;  assign obs_fwd[2]  = fwd_c;
  assign obs_sid[0]  = sid_a;  assign obs_sid[1]  = sid_b;  assign obs_sid[2]  = sid_c;
  assign obs_bex[0]  = bex_a;  assign obs_bex[1]  = bex_b;  assign obs_bex[2]  = bex_c;
  assign obs_sall[0] = sall_a; assign obs_sall[1] = sall_b; assign obs_sall[2] = sall_c;
  assign obs_lu[0]   = {12'b0, lu_a};  assign obs_lu[1]  = lu_b;  assign obs_lu[2]  = {8'b0, lu_c};
  assign obs_mem[0]  = {12'b0, mem_a}; assign obs_mem[1] = mem_b; assign obs_mem[2] = {8'b0, mem_c};

  // Reference model. blk = number of upcoming cycles in which a new load in
  // MEM is not accepted as a fresh trigger (L-2 freeze cycles + 1 release).
  int lat  [3] = '{3, 4, 1};
  int cmax [3] = '{15, 65535, 255};
  int blk  [3];
  int lu_m [3];
  int mem_m[3];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
    if (mem_reg_write && mem_reg_rd != 0 && mem_reg_rd == src) return 2'b01;
    if (wb_reg_write && wb_reg_rd != 0 && wb_reg_rd == src)    return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu_hit();
    return exe_mem_read && (exe_reg_rd != 0) && id_valid &&
           ((exe_reg_rd == id_src_addr[AW-1:0]) || (exe_reg_rd == id_src_addr[2*AW-1:AW]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      blk[i] = 0; lu_m[i] = 0; mem_m[i] = 0;
    end
  endtask

  // Check all outputs of all instances at the falling edge, advance the
  // model, then return 1 time unit after the next rising edge.
  task automatic cycle();
    bit st, sid;
    logic [3:0] fexp;
    @(negedge clk);
    fexp = {ref_fwd(exe_src_addr[2*AW-1:AW]), ref_fwd(exe_src_addr[AW-1:0])};
    for (int i = 0; i < 3; i++) begin
      st  = (blk[i] == 0) ? (mem_mem_read && lat[i] > 1) : (blk[i] > 1);
      sid = ref_lu_hit() && !st;
      check($sformatf("fwd_sel[%0d]", i),   obs_fwd[i],  fexp);
      check($sformatf("stall_all[%0d]", i), obs_sall[i], st);
      check($sformatf("stall_id[%0d]", i),  obs_sid[i],  sid);
      check($sformatf("bubble_ex[%0d]", i), obs_bex[i],  sid);
      check($sformatf("lu_cnt[%0d]", i),    obs_lu[i],   lu_m[i]);
      check($sformatf("mem_cnt[%0d]", i),   obs_mem[i],  mem_m[i]);
      if (!arst_n) begin
        blk[i] = 0; lu_m[i] = 0; mem_m[i] = 0;
      end else begin
        if (cnt_clr) begin
          lu_m[i] = 0; mem_m[i] = 0;
        end else begin
          if (sid && lu_m[i] < cmax[i]) lu_m[i]++;
          if (st && mem_m[i] < cmax[i]) mem_m[i]++;
        end
        if (blk[i] > 0) blk[i]--;
        else if (st)    blk[i] = lat[i] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_src_addr = '0; exe_src_addr = '0;
    exe_mem_read = 0; exe_reg_rd = '0; mem_mem_read = 0;
    mem_reg_rd = '0; mem_reg_write = 0; wb_reg_rd = '0; wb_reg_write = 0;
    cnt_clr = 0;
  endtask

  int mem_a0;

  initial begin
    idle_inputs();
    arst_n = 0;
    model_reset();

    // Reset state, checked with the clock running.
    #1;
    check("rst_stall_all_a", sall_a, 1'b0);
    check("rst_lu_a", lu_a, 4'd0);
    check("rst_mem_b", mem_b, 16'd0);
    cycle();
    cycle();
    arst_n = 1;
    cycle();

    // Forward priority: MEM over WB, then WB alone.
    mem_reg_write = 1; mem_reg_rd = 5'd3;
    wb_reg_write  = 1; wb_reg_rd  = 5'd3;
    exe_src_addr  = {5'd7, 5'd3};
    #1 check("fwd_prio_mem", fwd_a[1:0], 2'b01);
    check("fwd_op1_rf", fwd_a[3:2], 2'b00);
    cycle();
    mem_reg_write = 0;
    #1 check("fwd_prio_wb", fwd_a[1:0], 2'b10);
    cycle();

    // Register 0 never forwards.
    mem_reg_rd = 5'd0; mem_reg_write = 1; wb_reg_write = 0;
    exe_src_addr = {5'd0, 5'd0};
    #1 check("fwd_zero_reg", fwd_a[1:0], 2'b00);
    cycle();
    idle_inputs();

    // Load-use on operand 1 for one cycle.
    exe_mem_read = 1; exe_reg_rd = 5'd5; id_src_addr = {5'd5, 5'd9}; id_valid = 1;
    #1 check("lu_stall_id", sid_a, 1'b1);
    check("lu_bubble_ex", bex_a, 1'b1);
    check("lu_cnt_before", lu_a, 4'd0);
    cycle();
    idle_inputs();
    #1 check("lu_cnt_after", lu_a, 4'd1);
    check("lu_stall_id_clear", sid_a, 1'b0);
    cycle();

    // Load latency 3 on u_a: freeze at t and t+1, release at t+2.
    mem_a0 = int'(mem_a);
    mem_mem_read = 1;
    #1 check("lat_t_stall", sall_a, 1'b1);
    check("lat1_never_stalls", sall_c, 1'b0);
    cycle();
    check("lat_t1_stall", sall_a, 1'b1);
    cycle();
    check("lat_t2_release", sall_a, 1'b0);
    check("lat_mem_cnt_plus2", mem_a, 4'(mem_a0 + 2));
    cycle();
    mem_mem_read = 0;
    repeat (3) cycle();

    // Reset in the middle of u_b's wait (LOAD_LAT=4).
    mem_mem_read = 1;
    cycle();
    check("wait_before_rst", sall_b, 1'b1);
    mem_mem_read = 0;
    arst_n = 0;
    model_reset();
    #1 check("rst_mid_stall_all", sall_b, 1'b0);
    check("rst_mid_lu", lu_b, 16'd0);
    check("rst_mid_mem", mem_b, 16'd0);
    cycle();
    arst_n = 1;
    // First edge after reset evaluates from RUN: a new load freezes at once.
    mem_mem_read = 1;
    #1 check("post_rst_run", sall_b, 1'b1);
    repeat (4) cycle();
    mem_mem_read = 0;
    repeat (2) cycle();

    // Saturation of the 4-bit counter, then synchronous clear.
    for (int k = 0; k < 20; k++) begin
      exe_mem_read = 1; exe_reg_rd = 5'd5; id_src_addr = {5'd1, 5'd5}; id_valid = 1;
      cycle();
    end
    idle_inputs();
    #1 check("sat_lu_a", lu_a, 4'd15);
    check("sat_lu_b", lu_b, 16'd20);
    cnt_clr = 1;
    cycle();
    cnt_clr = 0;
    #1 check("clr_lu_a", lu_a, 4'd0);
    check("clr_lu_b", lu_b, 16'd0);

    // Randomized traffic with small address ranges to force frequent hits.
    for (int k = 0; k < 400; k++) begin
      id_valid      = 1'($urandom_range(0, 1));
      id_src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      exe_src_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      exe_mem_read  = 1'($urandom_range(0, 1));
      exe_reg_rd    = 5'($urandom_range(0, 3));
      mem_mem_read  = ($urandom_range(0, 3) == 0);
      mem_reg_rd    = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_rd     = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      cnt_clr       = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
